// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, access sizes,
// fault causes, RV32I load/store funct3 codes and the size-to-byte-count helper.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        NONE     = 2'b00,
        ILLEGAL  = 2'b01,
        MISALIGN = 2'b10,
        RANGE    = 2'b11
    } fault_cause_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    function automatic logic [2:0] access_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: access_bytes = 3'd1;
            SZ_HALF: access_bytes = 3'd2;
            default: access_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load-data formatter: selects byte/half/word from the raw memory
// word and sign- or zero-extends it according to the load funct3.
module load_formatter
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_raw,
    output logic [31:0] o_rdata
);

    always_comb begin
        case (i_funct3)
            F3_LB:   o_rdata = 32'($signed(i_raw[7:0]));
            F3_LH:   o_rdata = 32'($signed(i_raw[15:0]));
            F3_LBU:  o_rdata = {24'd0, i_raw[7:0]};
            F3_LHU:  o_rdata = {16'd0, i_raw[15:0]};
            default: o_rdata = i_raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: blocking IDLE -> ACCESS -> RESP FSM between execute and data memory.
// Optional alignment trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_SIZE = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [1:0]  rsp_cause,
    output logic        mem_write_en,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_store_size,
    output logic [31:0] mem_store_data,
    input  logic [31:0] mem_load_data
);

    lsu_state_e   r_state;
    logic         r_we;
    logic [2:0]   r_funct3;
    logic [31:0]  r_addr;
    logic [31:0]  r_wdata;
    logic         r_rsp_valid;
    logic [31:0]  r_rsp_rdata;
    logic         r_rsp_fault;
    fault_cause_e r_rsp_cause;

    logic         w_legal;
    logic         w_misaligned;
    logic         w_out_of_range;
    logic [32:0]  w_end_addr;
    fault_cause_e w_cause;
    logic [31:0]  w_fmt_rdata;

    always_comb begin
        if (req_we)
            w_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        else
            w_legal = (req_funct3 == F3_LB)  || (req_funct3 == F3_LH) || (req_funct3 == F3_LW) ||
                      (req_funct3 == F3_LBU) || (req_funct3 == F3_LHU);
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misaligned = ((req_funct3[1:0] == SZ_HALF) && req_addr[0]) ||
                          ((req_funct3[1:0] == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    // 33-bit end address so requests near 2^32 cannot wrap back into range
    assign w_end_addr     = {1'b0, req_addr} + 33'(access_bytes(req_funct3[1:0]));
    assign w_out_of_range = w_end_addr > 33'(MEM_SIZE);

    always_comb begin
        if (!w_legal)
            w_cause = ILLEGAL;
        else if (w_misaligned)
            w_cause = MISALIGN;
        else if (w_out_of_range)
            w_cause = RANGE;
        else
            w_cause = NONE;
    end

    load_formatter u_load_formatter (
        .i_funct3 (r_funct3),
        .i_raw    (mem_load_data),
        .o_rdata  (w_fmt_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_funct3    <= 3'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_fault <= 1'b0;
            r_rsp_cause <= NONE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        if (w_cause != NONE) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_fault <= 1'b1;
                            r_rsp_cause <= w_cause;
                            r_rsp_rdata <= 32'd0;
                            r_state     <= RESP;
                        end else begin
                            r_state     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_fault <= 1'b0;
                    r_rsp_cause <= NONE;
                    r_rsp_rdata <= r_we ? 32'd0 : w_fmt_rdata;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready      = (r_state == IDLE) && !reset;
    // Gated by reset so an aborted store never reaches memory
    assign mem_write_en   = (r_state == ACCESS) && r_we && !reset;
    assign mem_addr       = r_addr;
    assign mem_store_size = r_funct3[1:0];
    assign mem_store_data = r_wdata;

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_fault = r_rsp_fault;
    assign rsp_cause = r_rsp_cause;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a 512-byte little-endian memory model.
// Honours LSU_MISALIGN_TRAP_EN to select the expected misaligned-access behaviour.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [1:0]  rsp_cause;
    logic        mem_write_en;
    logic [31:0] mem_addr;
    logic [1:0]  mem_store_size;
    logic [31:0] mem_store_data;
    logic [31:0] mem_load_data;

    load_store_unit #(.MEM_SIZE(512)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_fault      (rsp_fault),
        .rsp_cause      (rsp_cause),
        .mem_write_en   (mem_write_en),
        .mem_addr       (mem_addr),
        .mem_store_size (mem_store_size),
        .mem_store_data (mem_store_data),
        .mem_load_data  (mem_load_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fault;
        logic [1:0]  cause;
        logic [31:0] rdata;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    logic [1:0]  last_wr_size = 2'b11;
    logic        prev_valid = 1'b0;
    logic [7:0]  mem [512];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: async little-endian read, byte-granular write
    always_comb begin
        mem_load_data = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if ({1'b0, mem_addr} + 33'(i) < 33'd512)
                mem_load_data[8*i +: 8] = mem[9'(mem_addr + 32'(i))];
        end
    end

    always @(posedge clk) begin
        if (mem_write_en) begin
            for (int i = 0; i < 4; i++) begin
                if ((i < ((mem_store_size == 2'b00) ? 1 : (mem_store_size == 2'b01) ? 2 : 4)) &&
                    ({1'b0, mem_addr} + 33'(i) < 33'd512))
                    mem[9'(mem_addr + 32'(i))] <= mem_store_data[8*i +: 8];
            end
        end
    end

    // Response monitor and write-pulse counter
    always @(negedge clk) begin
        exp_t e;
        if (mem_write_en) begin
            wr_cnt++;
            last_wr_size = mem_store_size;
        end
        if (!reset) begin
            if (rsp_valid && !prev_valid) begin
                if (q.size() == 0)
                    check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                else
                    check("rsp_latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
            end
            if (rsp_valid && rsp_ready && q.size() > 0) begin
                e = q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_fault", 32'(rsp_fault), 32'(e.fault));
                check("rsp_cause", 32'(rsp_cause), 32'(e.cause));
            end
        end
        prev_valid = rsp_valid;
    end

    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic ef, input logic [1:0] ec,
                        input logic [31:0] ed);
        exp_t e;
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 32'(req_ready), 32'd1);
        end else begin
            e.fault = ef; e.cause = ec; e.rdata = ed; e.acc = cyc; e.lat = ef ? 1 : 2;
            q.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            check("rsp_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        @(posedge clk);
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic ef, input logic [1:0] ec,
                         input logic [31:0] ed);
        send(we, f3, a, wd, ef, ec, ed);
        drain();
    endtask

    initial begin
        int wb;
        int n;
        logic [31:0] s_rdata;
        logic        s_fault;
        logic [1:0]  s_cause;

        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_fault", 32'(rsp_fault), 32'd0);
        check("reset_rsp_cause", 32'(rsp_cause), 32'd0);
        check("reset_mem_we", 32'(mem_write_en), 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_mem_size", 32'(mem_store_size), 32'd0);
        check("reset_mem_data", mem_store_data, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready), 32'd1);

        // Word store/load round trip
        wb = wr_cnt;
        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 2'b00, 32'h0);
        check("sw_write_pulses", 32'(wr_cnt - wb), 32'd1);
        check("sw_write_size", 32'(last_wr_size), 32'd2);
        wb = wr_cnt;
        issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 2'b00, 32'hDEADBEEF);
        check("lw_no_write", 32'(wr_cnt - wb), 32'd0);

        // Byte store writes one byte only
        issue(1'b1, 3'b000, 32'h20, 32'h12345680, 1'b0, 2'b00, 32'h0);
        check("sb_write_size", 32'(last_wr_size), 32'd0);
        issue(1'b0, F_LB(), 32'h20, 32'h0, 1'b0, 2'b00, 32'hFFFFFF80);
        issue(1'b0, 3'b100, 32'h20, 32'h0, 1'b0, 2'b00, 32'h00000080);
        issue(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 2'b00, 32'h00000080);

        // Half store / load
        issue(1'b1, 3'b001, 32'h30, 32'hCAFE8001, 1'b0, 2'b00, 32'h0);
        check("sh_write_size", 32'(last_wr_size), 32'd1);
        issue(1'b0, 3'b001, 32'h30, 32'h0, 1'b0, 2'b00, 32'hFFFF8001);
        issue(1'b0, 3'b101, 32'h30, 32'h0, 1'b0, 2'b00, 32'h00008001);
        issue(1'b0, 3'b010, 32'h30, 32'h0, 1'b0, 2'b00, 32'h00008001);

        // Range boundaries
        issue(1'b0, 3'b010, 32'h1FE, 32'h0, 1'b1, 2'b11, 32'h0);
        wb = wr_cnt;
        issue(1'b1, 3'b010, 32'h1FE, 32'h55555555, 1'b1, 2'b11, 32'h0);
        check("range_store_no_write", 32'(wr_cnt - wb), 32'd0);
        issue(1'b0, 3'b010, 32'h1FC, 32'h0, 1'b0, 2'b00, 32'h0);
        issue(1'b0, 3'b000, 32'h1FF, 32'h0, 1'b0, 2'b00, 32'h0);
        issue(1'b0, 3'b000, 32'h200, 32'h0, 1'b1, 2'b11, 32'h0);
        issue(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 1'b1, 2'b11, 32'h0);

        // Illegal funct3 and priority over other faults
        issue(1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 2'b01, 32'h0);
        wb = wr_cnt;
        issue(1'b1, 3'b100, 32'h10, 32'h0, 1'b1, 2'b01, 32'h0);
        check("illegal_store_no_write", 32'(wr_cnt - wb), 32'd0);
        issue(1'b0, 3'b111, 32'h1FF, 32'h0, 1'b1, 2'b01, 32'h0);

        // Misaligned accesses
        wb = wr_cnt;
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b1, 3'b010, 32'h13, 32'h11223344, 1'b1, 2'b10, 32'h0);
        check("misalign_sw_no_write", 32'(wr_cnt - wb), 32'd0);
        issue(1'b0, 3'b001, 32'h1FF, 32'h0, 1'b1, 2'b10, 32'h0);
`else
        issue(1'b1, 3'b010, 32'h13, 32'h11223344, 1'b0, 2'b00, 32'h0);
        check("misalign_sw_write", 32'(wr_cnt - wb), 32'd1);
        issue(1'b0, 3'b010, 32'h13, 32'h0, 1'b0, 2'b00, 32'h11223344);
        issue(1'b0, 3'b001, 32'h1FF, 32'h0, 1'b1, 2'b11, 32'h0);
`endif

        // Response back-pressure
        rsp_ready = 1'b0;
        send(1'b0, 3'b101, 32'h30, 32'h0, 1'b0, 2'b00, 32'h00008001);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        s_rdata = rsp_rdata; s_fault = rsp_fault; s_cause = rsp_cause;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid_held", 32'(rsp_valid), 32'd1);
            check("stall_rdata_held", rsp_rdata, s_rdata);
            check("stall_fault_held", 32'({rsp_fault, rsp_cause}), 32'({s_fault, s_cause}));
            check("stall_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_req_ready", 32'(req_ready), 32'd1);
        check("release_rsp_valid", 32'(rsp_valid), 32'd0);
        check("release_drained", 32'(q.size()), 32'd0);

        // Reset during ACCESS of a store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'hA5A5A5A5;
        check("abort_req_ready", 32'(req_ready), 32'd1);
        wb = wr_cnt;
        @(posedge clk); #1 reset = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        check("abort_no_write", 32'(mem_write_en), 32'd0);
        check("abort_req_ready_low", 32'(req_ready), 32'd0);
        @(negedge clk);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_req_ready_back", 32'(req_ready), 32'd1);
        check("abort_write_count", 32'(wr_cnt - wb), 32'd0);
        issue(1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 2'b00, 32'h0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic [2:0] F_LB();
        return 3'b000;
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
